// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave scheduler: core register map, FSM
// states and the Wishbone request payload.
package spi_pkg;

  localparam logic [1:0] SPCR = 2'b00;
  localparam logic [1:0] SPSR = 2'b01;
  localparam logic [1:0] SPDR = 2'b10;
  localparam logic [1:0] SPER = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WR_SPCR,
    WR_SPER,
    RUN
  } state_e;

  typedef struct packed {
    logic       cyc;
    logic       stb;
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } wb_req_t;

  // Single-beat register write request.
  function automatic wb_req_t wb_write(input logic [1:0] a, input logic [7:0] d);
    wb_req_t r;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.we  = 1'b1;
    r.adr = a;
    r.dat = d;
    return r;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Circular TX byte queue; full/empty are registered alongside the count.
module spi_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is dropped even when a pop frees a slot this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  always_comb begin
    count_d = count_o;
    if (push_ok && !pop_ok) begin
      count_d = count_o + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_o - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_d;
      full_o  <= (count_d == CW'(DEPTH));
      empty_o <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/spi_slave_sched.sv
// Slave-side scheduler for spi_combine: configures the core over Wishbone,
// then issues one tx_valid per SPI byte slot and forwards received bytes.
module spi_slave_sched
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  SPCR_VAL    = 8'hD3,
  parameter logic [7:0]  SPER_VAL    = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cfg_start_i,
  output logic       cfg_done_o,
  output logic       cfg_err_o,
  input  logic       tx_push_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_full_o,
  output logic       tx_empty_o,
  output logic       ovf_o,
  output logic       udf_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o,
  input  logic       ssn_i,
  output logic       stb_o,
  output logic       cyc_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic       ack_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  state_e           state_q;
  state_e           state_d;
  wb_req_t          wb_q;
  wb_req_t          wb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;
  logic             flush_c;

  logic             ssn_s1;
  logic             ssn_s2;
  logic             ssn_s3;
  logic             run_c;
  logic             slot_c;
  logic             pop_c;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;

  assign cyc_o = wb_q.cyc;
  assign stb_o = wb_q.stb;
  assign we_o  = wb_q.we;
  assign adr_o = wb_q.adr;
  assign dat_o = wb_q.dat;

  // Each write holds the strobe until ack, then spends one idle cycle in the
  // same state before moving on, giving the gap between bus writes.
  always_comb begin
    state_d = state_q;
    wb_d    = '0;
    cnt_d   = cnt_q;
    err_d   = cfg_err_o;
    flush_c = 1'b0;
    if (cfg_start_i) begin
      state_d = WR_SPCR;
      wb_d    = wb_write(SPCR, SPCR_VAL);
      cnt_d   = CNT_W'(ACK_TIMEOUT);
      err_d   = 1'b0;
      flush_c = 1'b1;
    end else begin
      case (state_q)
        WR_SPCR, WR_SPER: begin
          if (wb_q.stb) begin
            if (!ack_i) begin
              if (cnt_q <= CNT_W'(1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
              end else begin
                wb_d  = wb_q;
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end else if (state_q == WR_SPCR) begin
            state_d = WR_SPER;
            wb_d    = wb_write(SPER, SPER_VAL);
            cnt_d   = CNT_W'(ACK_TIMEOUT);
          end else begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      wb_q       <= '0;
      cnt_q      <= '0;
      cfg_err_o  <= 1'b0;
      cfg_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      cnt_q      <= cnt_d;
      cfg_err_o  <= err_d;
      cfg_done_o <= (state_d == RUN);
    end
  end

  // Slot: synchronized ssn fall, or a received byte while still selected.
  assign run_c  = (state_q == RUN);
  assign slot_c = run_c && !ssn_s2 && (ssn_s3 || rx_valid_i);
  assign pop_c  = slot_c && !tx_empty_o;

  spi_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_c),
    .push_i  (tx_push_i),
    .data_i  (tx_byte_i),
    .pop_i   (pop_c),
    .data_o  (fifo_head),
    .full_o  (tx_full_o),
    .empty_o (tx_empty_o),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ssn_s1          <= 1'b1;
      ssn_s2          <= 1'b1;
      ssn_s3          <= 1'b1;
      tx_valid_o      <= 1'b0;
      tx_data_o       <= '0;
      udf_o           <= 1'b0;
      ovf_o           <= 1'b0;
      rx_byte_o       <= '0;
      rx_byte_valid_o <= 1'b0;
    end else begin
      ssn_s1          <= ssn_i;
      ssn_s2          <= ssn_s1;
      ssn_s3          <= ssn_s2;
      tx_valid_o      <= slot_c;
      rx_byte_valid_o <= run_c && rx_valid_i;
      if (slot_c) begin
        tx_data_o <= tx_empty_o ? 8'h00 : fifo_head;
        if (tx_empty_o) udf_o <= 1'b1;
      end
      if (tx_push_i && (fifo_count == CW'(DEPTH))) ovf_o <= 1'b1;
      if (run_c && rx_valid_i) rx_byte_o <= rx_data_i;
    end
  end

endmodule

// File: tb/tb_spi_slave_sched.sv
// Scenario bench for spi_slave_sched; TX/RX/Wishbone expectations are queued
// as stimulus is applied and popped when the DUT responds.
module tb_spi_slave_sched;

  localparam int unsigned DEPTH = 4;
  localparam logic [36:0] RST_OUTS = 37'(1) << 33;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       cfg_start_i;
  logic       cfg_done_o;
  logic       cfg_err_o;
  logic       tx_push_i;
  logic [7:0] tx_byte_i;
  logic       tx_full_o;
  logic       tx_empty_o;
  logic       ovf_o;
  logic       udf_o;
  logic [7:0] rx_byte_o;
  logic       rx_byte_valid_o;
  logic       ssn_i;
  logic       stb_o;
  logic       cyc_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [9:0] exp_wb[$];
  logic       exp_udf = 1'b0;
  logic       exp_ovf = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_slave_sched dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .cfg_start_i     (cfg_start_i),
    .cfg_done_o      (cfg_done_o),
    .cfg_err_o       (cfg_err_o),
    .tx_push_i       (tx_push_i),
    .tx_byte_i       (tx_byte_i),
    .tx_full_o       (tx_full_o),
    .tx_empty_o      (tx_empty_o),
    .ovf_o           (ovf_o),
    .udf_o           (udf_o),
    .rx_byte_o       (rx_byte_o),
    .rx_byte_valid_o (rx_byte_valid_o),
    .ssn_i           (ssn_i),
    .stb_o           (stb_o),
    .cyc_o           (cyc_o),
    .we_o            (we_o),
    .adr_o           (adr_o),
    .dat_o           (dat_o),
    .ack_i           (ack_i),
    .tx_valid_o      (tx_valid_o),
    .tx_data_o       (tx_data_o),
    .rx_valid_i      (rx_valid_i),
    .rx_data_i       (rx_data_i)
  );

  function automatic logic [36:0] outs();
    return {cfg_done_o, cfg_err_o, tx_full_o, tx_empty_o, ovf_o, udf_o,
            rx_byte_o, rx_byte_valid_o, stb_o, cyc_o, we_o, adr_o, dat_o,
            tx_valid_o, tx_data_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_byte_i = b;
    tx_push_i = 1'b1;
    if (exp_tx.size() < DEPTH) exp_tx.push_back(b);
    else exp_ovf = 1'b1;
    step();
    tx_push_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b1; cfg_start_i = 1'b0; tx_push_i = 1'b0; tx_byte_i = '0;
    ssn_i = 1'b1; ack_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    #1 rstn_i = 1'b0;
    #1;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL reset_outs: got %h want %h", outs(), RST_OUTS);
    end
    repeat (3) step();
    rstn_i = 1'b1;
    step();
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", outs(), RST_OUTS);
    end
  endtask

  // k = stb cycle in which ack is returned (1 = zero-wait).
  task automatic test_config(input int k);
    int t, first_stb, done_t, hi;
    logic [9:0] e;
    exp_wb.push_back({2'b00, 8'hD3});
    exp_wb.push_back({2'b11, 8'h00});
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    first_stb = -1; done_t = -1; hi = 0;
    for (t = 1; t <= 40; t++) begin
      if (cfg_done_o) begin
        done_t = t;
        break;
      end
      if (stb_o) begin
        if (first_stb < 0) first_stb = t;
        hi++;
        ack_i = (hi == k);
        if (hi == k) begin
          e = (exp_wb.size() > 0) ? exp_wb.pop_front() : 10'h3FF;
          checks++;
          if ({cyc_o, we_o, adr_o, dat_o} !== {2'b11, e}) begin
            errors++;
            $display("FAIL cfg_write k=%0d: got cyc/we/adr/dat %b%b %h %h want 11 %h %h",
                     k, cyc_o, we_o, adr_o, dat_o, e[9:8], e[7:0]);
          end
        end
      end else begin
        hi = 0;
        ack_i = 1'b0;
      end
      step();
    end
    ack_i = 1'b0;
    checks++;
    if (first_stb != 1) begin
      errors++;
      $display("FAIL cfg_stb_rise k=%0d: got cycle %0d want 1", k, first_stb);
    end
    checks++;
    if (done_t != 2 * k + 3) begin
      errors++;
      $display("FAIL cfg_done_time k=%0d: got cycle %0d want %0d", k, done_t, 2 * k + 3);
    end
    checks++;
    if (exp_wb.size() != 0 || cfg_err_o !== 1'b0) begin
      errors++;
      $display("FAIL cfg_complete k=%0d: pending writes %0d err %b want 0 0",
               k, exp_wb.size(), cfg_err_o);
      exp_wb.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    ack_i = 1'b0;
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    n = 0;
    while (stb_o && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL timeout_len: got %0d stb cycles want 15", n);
    end
    checks++;
    if ({cfg_err_o, cfg_done_o} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_flags: got err/done %b%b want 10", cfg_err_o, cfg_done_o);
    end
    repeat (5) step();
    checks++;
    if ({stb_o, cyc_o, cfg_err_o} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_idle: got stb/cyc/err %b%b%b want 001", stb_o, cyc_o, cfg_err_o);
    end
  endtask

  // ssn fall slot: tx_valid must appear 3 cycles later with the queue head.
  task automatic test_ssn_fall_slot();
    int n;
    logic [7:0] et;
    et = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
    ssn_i = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_valid_o && n < 10);
    checks++;
    if (n != 3 || tx_data_o !== et) begin
      errors++;
      $display("FAIL ssn_slot: got latency %0d data %h want 3 %h", n, tx_data_o, et);
    end
  endtask

  // One SPI byte time, then the core reports a received byte.
  task automatic test_rx_slot(input logic [7:0] d);
    logic [7:0] et, er;
    repeat (16) step();
    if (exp_tx.size() > 0) et = exp_tx.pop_front();
    else begin
      et = 8'h00;
      exp_udf = 1'b1;
    end
    exp_rx.push_back(d);
    rx_data_i = d;
    rx_valid_i = 1'b1;
    step();
    rx_valid_i = 1'b0;
    er = exp_rx.pop_front();
    checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, et}) begin
      errors++;
      $display("FAIL rx_slot_tx: got valid %b data %h want 1 %h", tx_valid_o, tx_data_o, et);
    end
    checks++;
    if ({rx_byte_valid_o, rx_byte_o} !== {1'b1, er}) begin
      errors++;
      $display("FAIL rx_forward: got valid %b byte %h want 1 %h", rx_byte_valid_o, rx_byte_o, er);
    end
    step();
    checks++;
    if ({tx_valid_o, rx_byte_valid_o, tx_data_o, udf_o} !== {2'b00, et, exp_udf}) begin
      errors++;
      $display("FAIL rx_slot_after: got txv %b rxv %b data %h udf %b want 0 0 %h %b",
               tx_valid_o, rx_byte_valid_o, tx_data_o, udf_o, et, exp_udf);
    end
  endtask

  task automatic test_frame();
    push_byte(8'h45);
    push_byte(8'hB4);
    checks++;
    if ({tx_empty_o, tx_full_o} !== 2'b00) begin
      errors++;
      $display("FAIL frame_queue: got empty/full %b%b want 00", tx_empty_o, tx_full_o);
    end
    test_ssn_fall_slot();
    test_rx_slot(8'h91);
    test_rx_slot(8'hB6);
    test_rx_slot(8'h3C);
    ssn_i = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_wrap();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    checks++;
    if (tx_full_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_not_full: got %b want 0", tx_full_o);
    end
    push_byte(8'hA4);
    checks++;
    if (tx_full_o !== 1'b1 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full: got full %b ovf %b want 1 0", tx_full_o, ovf_o);
    end
    push_byte(8'hA5);
    step();
    checks++;
    if ({tx_full_o, ovf_o} !== {1'b1, exp_ovf}) begin
      errors++;
      $display("FAIL wrap_ovf: got full %b ovf %b want 1 %b", tx_full_o, ovf_o, exp_ovf);
    end
    test_ssn_fall_slot();
    test_rx_slot(8'h11);
    test_rx_slot(8'h22);
    test_rx_slot(8'h33);
    checks++;
    if (tx_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_drained: got empty %b want 1", tx_empty_o);
    end
    push_byte(8'hC1);
    push_byte(8'hC2);
    test_rx_slot(8'h44);
    test_rx_slot(8'h55);
    ssn_i = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    push_byte(8'h9A);
    push_byte(8'h9B);
    test_ssn_fall_slot();
    repeat (5) step();
    #2 rstn_i = 1'b0;
    #1;
    exp_tx.delete();
    exp_udf = 1'b0;
    exp_ovf = 1'b0;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL mid_reset_outs: got %h want %h", outs(), RST_OUTS);
    end
    ssn_i = 1'b1;
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (3) step();
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL mid_reset_release: got %h want %h", outs(), RST_OUTS);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_config(3);
    test_timeout();
    test_config(1);
    test_frame();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
